// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`ifndef PC_INIT
`define PC_INIT 64'h8000_0000
`endif

package fetch_pkg;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO between fetch and decode; head is read straight from storage.
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_pkg::fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        wdata_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, feeds instruction memory and buffers words for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] PC_INIT = `PC_INIT,
  parameter int          DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] mem_pc_o,
  input  logic [31:0] mem_inst_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        halted_o,
  output logic        misalign_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          misalign_q, misalign_d;

  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;

  assign pop = ~fifo_empty & inst_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    push       = 1'b0;
    if (redirect_i) begin
      pc_d    = align_pc(redirect_pc_i);
      state_d = RUN;
      if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (state_q == RUN && (!fifo_full || pop)) begin
      push = 1'b1;
      pc_d = pc_q + 64'd4;
      if (mem_inst_i == EBREAK) state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= PC_INIT;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // A redirect flushes the FIFO, so any same-cycle pop is simply dropped.
  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop & ~redirect_i),
    .flush_i (redirect_i),
    .wdata_i ('{pc: pc_q, inst: mem_inst_i}),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_pc_o     = pc_q;
  assign inst_valid_o = (fifo_count != '0);
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;
  assign halted_o     = (state_q == HALT);
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Random and directed stimulus against a queue-based reference model with a decoupled scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [63:0] PC_INIT = 64'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] EBRK    = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] mem_pc_o;
  logic [31:0] mem_inst_i;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;
  logic        halted_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  fetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_pc_o      (mem_pc_o),
    .mem_inst_i    (mem_inst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o)
  );

  // Instruction memory: 64 words, aliased across the address space.
  logic [31:0] imem [64];
  assign mem_inst_i = imem[mem_pc_o[7:2]];

  // Reference model: architectural view only (PC, occupancy, halt, sticky flag).
  logic [63:0]  m_pc;
  int           m_cnt;
  bit           m_halt;
  bit           m_mis;
  bit           m_known = 1'b0;
  fetch_entry_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          pop;
    logic [31:0] word;
    if (m_known) begin
      check("mem_pc", mem_pc_o, m_pc);
      check("halted", {63'b0, halted_o}, {63'b0, m_halt});
      check("misalign", {63'b0, misalign_o}, {63'b0, m_mis});
      check("inst_valid", {63'b0, inst_valid_o}, {63'b0, (m_cnt > 0)});
    end
    if (rst) begin
      m_pc    = PC_INIT;
      m_cnt   = 0;
      m_halt  = 1'b0;
      m_mis   = 1'b0;
      m_known = 1'b1;
      exp_q.delete();
    end else if (redirect_i) begin
      m_cnt  = 0;
      exp_q.delete();
      m_pc   = redirect_pc_i & ~64'd3;
      m_halt = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      pop = (m_cnt > 0) && inst_ready_i;
      if (!m_halt && (m_cnt < DEPTH || pop)) begin
        word = imem[m_pc[7:2]];
        exp_q.push_back('{pc: m_pc, inst: word});
        m_cnt = m_cnt + 1;
        m_pc  = m_pc + 64'd4;
        if (word == EBRK) m_halt = 1'b1;
      end
      if (pop) m_cnt = m_cnt - 1;
    end
  endtask

  task automatic cycle(input bit rdy, input bit rd, input logic [63:0] tgt, input bit rs);
    @(negedge clk);
    inst_ready_i  = rdy;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    rst           = rs;
    #2;
    model_step();
  endtask

  // Monitor: every accepted head is compared against the oldest expected entry.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && !redirect_i && inst_valid_o === 1'b1 && inst_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual pc=%h required=no_entry", inst_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("head_pc", inst_pc_o, e.pc);
          check("head_inst", {32'b0, inst_o}, {32'b0, e.inst});
          $display("ACCEPT pc=%h inst=%h", inst_pc_o, inst_o);
        end
      end
    end
  end

  initial begin
    int r;
    logic [63:0] tgt;
    for (int i = 0; i < 64; i++) imem[i] = NOP;

    repeat (2) cycle(1, 0, 0, 1);
    repeat (12) cycle(1, 0, 0, 0);
    // Backpressure until full, then drain.
    repeat (10) cycle(0, 0, 0, 0);
    repeat (6) cycle(1, 0, 0, 0);
    // Full FIFO with a single-cycle simultaneous push/pop.
    repeat (6) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    // Redirect with entries buffered.
    cycle(1, 1, 64'h8000_0100, 0);
    repeat (4) cycle(1, 0, 0, 0);
    // ebreak at 0x8000_0008, then drain and restart.
    imem[2] = EBRK;
    cycle(0, 1, 64'h8000_0000, 0);
    repeat (6) cycle(0, 0, 0, 0);
    repeat (5) cycle(1, 0, 0, 0);
    cycle(1, 1, 64'h8000_0000, 0);
    imem[2] = NOP;
    repeat (4) cycle(1, 0, 0, 0);
    // Misaligned redirect, 64-bit PC wrap, then reset mid-stream.
    cycle(1, 1, 64'h8000_0102, 0);
    repeat (5) cycle(1, 0, 0, 0);
    cycle(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    repeat (5) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    repeat (3) cycle(1, 0, 0, 0);

    // Randomised phase.
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 15);
      imem[i] = (r == 0) ? EBRK : (r < 4) ? $urandom : NOP;
    end
    for (int n = 0; n < 800; n++) begin
      tgt = 64'h8000_0000 | 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), tgt,
            ($urandom_range(0, 199) == 0));
    end
    repeat (DEPTH + 4) cycle(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory and downstream-facing to decode. Owns the program counter, drives the fetch address to the combinational instruction memory, and captures the returned word together with its PC into a small FIFO. Decode drains the FIFO over a valid/ready handshake. Execute redirects fetch on taken branches and jumps; fetch halts itself after fetching `ebreak`.

## Interface
- `PC_INIT`, default 64'h8000_0000: reset PC. Identical to the global `PC_INIT` define.
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mem_pc_o` output 64: fetch address to instruction memory; equals the internal PC register.
- `mem_inst_i` input 32: instruction word returned combinationally by memory for `mem_pc_o` in the same cycle.
- `redirect_i` input 1: execute requests a PC change this cycle.
- `redirect_pc_i` input 64: new PC; valid when `redirect_i`=1.
- `inst_valid_o` output 1: FIFO head is valid.
- `inst_o` output 32: head instruction.
- `inst_pc_o` output 64: PC of head instruction.
- `inst_ready_i` input 1: decode accepts the head this cycle.
- `halted_o` output 1: fetch is in HALT.
- `misalign_o` output 1: sticky flag; a redirect target had `[1:0]`≠0.

## Operation
- State machine: RUN and HALT.
- pop = `inst_valid_o` & `inst_ready_i`.
- push = RUN & !`redirect_i` & (count<DEPTH | pop).
- On push:
  - enqueue {`mem_pc_o`, `mem_inst_i`};
  - PC += 4, with 64-bit wrap and no overflow flag;
  - if `mem_inst_i`==32'h0010_0073 (`ebreak`), go to HALT after the push.
- In HALT:
  - no pushes, and PC holds;
  - the FIFO keeps draining to decode.
- On `redirect_i`, which has highest priority:
  - flush the FIFO, so count becomes 0 and any same-cycle pop is discarded;
  - PC ← {`redirect_pc_i[63:2]`, 2'b00};
  - state ← RUN, even if it was HALT;
  - no push that cycle;
  - if `redirect_pc_i[1:0]`≠0, set `misalign_o`.
- `misalign_o` clears only on `rst`.
- Count width is $clog2(DEPTH)+1. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop:
  - count is unchanged;
  - allowed when full;
  - when empty, only the push takes effect because `inst_valid_o`=0, so no pop occurs. There is no bypass.

## Timing
- Reset values:
  - PC=`PC_INIT`, so `mem_pc_o`=`PC_INIT` in the first cycle after reset;
  - FIFO empty, `inst_valid_o`=0;
  - state RUN, `halted_o`=0, `misalign_o`=0.
- `inst_o` and `inst_pc_o` are don't-care while `inst_valid_o`=0.
- Latency: a word pushed in cycle N is visible at the head no earlier than N+1.
- Steady state with `inst_ready_i` held at 1 gives one instruction per cycle.
- Redirect asserted in cycle N:
  - `mem_pc_o` shows the target in N+1;
  - `inst_valid_o`=0 in N+1;
  - the target instruction is at the head in N+2.
- `halted_o` rises the cycle after `ebreak` is pushed.
- Reset asserted mid-operation overrides redirect, push and pop, and restores all reset values on the next edge.
- Outputs are registered, except:
  - `mem_pc_o`, which is the PC register itself;
  - `inst_o`/`inst_pc_o`, which are read from the FIFO head.

## Structure
- Package `fetch_pkg` holds:
  - the `EBREAK` constant 32'h0010_0073;
  - the state enum {RUN, HALT};
  - the FIFO entry struct {pc[63:0], inst[31:0]}.
- Sub-module `fetch_fifo`, parameterised by `DEPTH` and the entry type:
  - push, pop, flush;
  - count, head, full, empty.
- `fetch_unit` holds the PC register, the FSM, and the misalign flag.

## Test plan
- Reset then `inst_ready_i`=1, memory at `PC_INIT` holding 0x00000013 ×8 → heads at cycles 2..9 carry PCs 0x8000_0000, 0x8000_0004, …, `inst_o`=0x00000013.
- `inst_ready_i`=0 for 10 cycles → count saturates at 4, `mem_pc_o` stops at 0x8000_0010. Then ready=1 → 4 buffered PCs drain in order with no gap, and fetch resumes at 0x8000_0010.
- FIFO full, ready=1 for one cycle → simultaneous push/pop, count stays 4, PC advances by exactly 4.
- `redirect_i`=1 with target 0x8000_0100 while 3 entries are buffered → next cycle `inst_valid_o`=0 and `mem_pc_o`=0x8000_0100; the cycle after that the head PC is 0x8000_0100.
- `ebreak` at 0x8000_0008 → `halted_o`=1 after the push, PC frozen at 0x8000_000C, three entries drain then `inst_valid_o`=0. A following redirect to 0x8000_0000 → `halted_o`=0 and fetch restarts.
- Redirect to 0x8000_0102 → `mem_pc_o`=0x8000_0100, `misalign_o`=1 and it stays 1 until `rst`. Asserting `rst` mid-stream → all reset values on the next edge.
